// File: rtl/sram_controller_pkg.sv
// Shared definitions for the MEM-stage SRAM controller.
// Holds the FSM state encoding, default geometry/timing constants and the
// byte-address to SRAM word-index mapping.
package sram_controller_pkg;

  localparam int unsigned SRAM_WAIT_CYCLES = 1;
  localparam int unsigned SRAM_ADDR_BASE   = 1024;
  localparam int unsigned SRAM_ADDR_W      = 18;
  localparam int unsigned SRAM_DATA_W      = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLo   = 2'd1,
    StHi   = 2'd2,
    StDone = 2'd3
  } sram_state_e;

  // 32-bit word index relative to the SRAM base, wrapped to 17 bits so that
  // {index, half} fits the 18-bit half-word address bus.
  function automatic logic [16:0] word_index(input logic [31:0] addr, input logic [31:0] base);
    return 17'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller.sv
// SRAM controller: turns a 32-bit MEM-stage load/store into two 16-bit SRAM
// half accesses (low half first), stalling the pipeline through ready.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   wr_en, rd_en      store / load request, held stable while ready=0
//   address           byte address (ALU result)
//   write_data        store data
//   read_data         load result, valid in DONE and held afterwards
//   ready             0 freezes the pipeline
//   sram_addr         half-word address to the SRAM
//   sram_dq_out       write data to the SRAM, driven when sram_dq_oe=1
//   sram_dq_in        read data from the SRAM
//   sram_dq_oe        drive enable for sram_dq_out
//   sram_we_n         active-low write strobe
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = SRAM_WAIT_CYCLES,
  parameter int unsigned ADDR_BASE   = SRAM_ADDR_BASE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  localparam logic [3:0] WaitLast = 4'(WAIT_CYCLES);

  sram_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_wr_q, is_wr_d;
  logic [31:0] rdata_q, rdata_d;

  logic [16:0] idx;
  logic        last;

  assign idx       = word_index(address, 32'(ADDR_BASE));
  assign last      = (cnt_q == WaitLast);
  assign read_data = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      is_wr_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    rdata_d     = rdata_q;
    ready       = 1'b1;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;

    unique case (state_q)
      StIdle: begin
        ready = !(wr_en || rd_en);
        if (wr_en || rd_en) begin
          state_d = StLo;
          cnt_d   = 4'd0;
          // Write wins when both requests are present.
          is_wr_d = wr_en;
        end
      end
      StLo: begin
        ready       = 1'b0;
        sram_addr   = {idx, 1'b0};
        sram_dq_out = write_data[15:0];
        sram_dq_oe  = is_wr_q;
        sram_we_n   = !is_wr_q;
        if (last) begin
          state_d = StHi;
          cnt_d   = 4'd0;
          if (!is_wr_q) rdata_d[15:0] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StHi: begin
        ready       = 1'b0;
        sram_addr   = {idx, 1'b1};
        sram_dq_out = write_data[31:16];
        sram_dq_oe  = is_wr_q;
        sram_we_n   = !is_wr_q;
        if (last) begin
          state_d = StDone;
          cnt_d   = 4'd0;
          if (!is_wr_q) rdata_d[31:16] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        // Requests still asserted here are ignored; IDLE samples them again.
        ready   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

  logic        clk;
  logic        rst         [2];
  logic        wr_en       [2];
  logic        rd_en       [2];
  logic [31:0] address     [2];
  logic [31:0] write_data  [2];
  logic [31:0] read_data   [2];
  logic        ready       [2];
  logic [17:0] sram_addr   [2];
  logic [15:0] sram_dq_out [2];
  logic [15:0] sram_dq_in  [2];
  logic        sram_dq_oe  [2];
  logic        sram_we_n   [2];

  // SRAM models (async read, write on rising edge while we_n low).
  logic [15:0] mem0 [0:262143];
  logic [15:0] mem1 [0:262143];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: WAIT_CYCLES=0, instance 1: WAIT_CYCLES=1.
  sram_controller #(.WAIT_CYCLES(0), .ADDR_BASE(1024)) u_dut0 (
    .clk        (clk),
    .rst        (rst[0]),
    .wr_en      (wr_en[0]),
    .rd_en      (rd_en[0]),
    .address    (address[0]),
    .write_data (write_data[0]),
    .read_data  (read_data[0]),
    .ready      (ready[0]),
    .sram_addr  (sram_addr[0]),
    .sram_dq_out(sram_dq_out[0]),
    .sram_dq_in (sram_dq_in[0]),
    .sram_dq_oe (sram_dq_oe[0]),
    .sram_we_n  (sram_we_n[0])
  );

  sram_controller #(.WAIT_CYCLES(1), .ADDR_BASE(1024)) u_dut1 (
    .clk        (clk),
    .rst        (rst[1]),
    .wr_en      (wr_en[1]),
    .rd_en      (rd_en[1]),
    .address    (address[1]),
    .write_data (write_data[1]),
    .read_data  (read_data[1]),
    .ready      (ready[1]),
    .sram_addr  (sram_addr[1]),
    .sram_dq_out(sram_dq_out[1]),
    .sram_dq_in (sram_dq_in[1]),
    .sram_dq_oe (sram_dq_oe[1]),
    .sram_we_n  (sram_we_n[1])
  );

  assign sram_dq_in[0] = mem0[sram_addr[0]];
  assign sram_dq_in[1] = mem1[sram_addr[1]];

  always @(posedge clk) begin
    if (!sram_we_n[0]) mem0[sram_addr[0]] <= sram_dq_out[0];
    if (!sram_we_n[1]) mem1[sram_addr[1]] <= sram_dq_out[1];
  end

  typedef struct {
    int          sel;
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_low;
    int          exp_we;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Counts ready-low cycles and we_n-low cycles until ready rises (DONE).
  task automatic wait_done(input int s, output int low, output int welow);
    bit done;
    done  = 1'b0;
    low   = 0;
    welow = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      #1;
      if (!sram_we_n[s]) welow++;
      if (ready[s]) done = 1'b1;
      else begin
        low++;
        @(negedge clk);
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL timeout: inst=%0d ready never rose, required within 64 cycles", s);
    end
  endtask

  task automatic access(input int s, input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] wdata, output int low, output int welow);
    @(negedge clk);
    wr_en[s]      = wr;
    rd_en[s]      = rd;
    address[s]    = addr;
    write_data[s] = wdata;
    wait_done(s, low, welow);
  endtask

  task automatic go_idle(input int s);
    @(negedge clk);
    wr_en[s] = 1'b0;
    rd_en[s] = 1'b0;
  endtask

  initial begin
    int low, welow;
    logic [15:0] pre13;

    vecs[0] = '{1, 1'b1, 1'b0, 32'd1024, 32'h12345678, 5, 4, 32'h00000000};
    vecs[1] = '{1, 1'b0, 1'b1, 32'd1024, 32'h00000000, 5, 0, 32'h12345678};
    vecs[2] = '{0, 1'b1, 1'b0, 32'd1028, 32'hCAFEBABE, 3, 2, 32'h00000000};
    vecs[3] = '{0, 1'b1, 1'b1, 32'd1032, 32'h0000A5A5, 3, 2, 32'h00000000};
    vecs[4] = '{0, 1'b0, 1'b1, 32'd1028, 32'h00000000, 3, 0, 32'hCAFEBABE};
    vecs[5] = '{1, 1'b1, 1'b1, 32'd1032, 32'h0000A5A5, 5, 4, 32'h12345678};
    vecs[6] = '{1, 1'b0, 1'b1, 32'd1032, 32'h00000000, 5, 0, 32'h0000A5A5};
    vecs[7] = '{1, 1'b1, 1'b0, 32'd1020, 32'h0BADF00D, 5, 4, 32'h0000A5A5};
    vecs[8] = '{1, 1'b0, 1'b1, 32'd1020, 32'h00000000, 5, 0, 32'h0BADF00D};

    for (int s = 0; s < 2; s++) begin
      rst[s]        = 1'b1;
      wr_en[s]      = 1'b0;
      rd_en[s]      = 1'b0;
      address[s]    = 32'd0;
      write_data[s] = 32'd0;
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    #1;
    chk("reset ready", {31'd0, ready[1]}, 32'd1);
    chk("reset we_n", {31'd0, sram_we_n[1]}, 32'd1);
    chk("reset oe", {31'd0, sram_dq_oe[1]}, 32'd0);
    chk("reset sram_addr", {14'd0, sram_addr[1]}, 32'd0);
    chk("reset dq_out", {16'd0, sram_dq_out[1]}, 32'd0);
    chk("reset read_data", read_data[1], 32'd0);
    chk("reset read_data inst0", read_data[0], 32'd0);

    for (int i = 0; i < 9; i++) begin
      access(vecs[i].sel, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, low, welow);
      chk($sformatf("vec%0d ready-low cycles", i), 32'(low), 32'(vecs[i].exp_low));
      chk($sformatf("vec%0d we_n-low cycles", i), 32'(welow), 32'(vecs[i].exp_we));
      chk($sformatf("vec%0d read_data", i), read_data[vecs[i].sel], vecs[i].exp_rd);
      go_idle(vecs[i].sel);
    end

    chk("mem1[0]", {16'd0, mem1[0]}, 32'h5678);
    chk("mem1[1]", {16'd0, mem1[1]}, 32'h1234);
    chk("mem0[2]", {16'd0, mem0[2]}, 32'hBABE);
    chk("mem0[3]", {16'd0, mem0[3]}, 32'hCAFE);
    chk("mem0[4]", {16'd0, mem0[4]}, 32'hA5A5);
    chk("mem0[5]", {16'd0, mem0[5]}, 32'h0000);
    chk("mem1[4]", {16'd0, mem1[4]}, 32'hA5A5);
    chk("mem1 wrap lo", {16'd0, mem1[18'h3FFFE]}, 32'hF00D);
    chk("mem1 wrap hi", {16'd0, mem1[18'h3FFFF]}, 32'h0BAD);

    // Read holds after idle cycles.
    @(negedge clk);
    @(negedge clk);
    chk("read_data held", read_data[1], 32'h0BADF00D);

    // Back-to-back write then read: second access starts in the IDLE after DONE.
    access(1, 1'b1, 1'b0, 32'd1040, 32'hDEADBEEF, low, welow);
    chk("b2b write low", 32'(low), 32'd5);
    access(1, 1'b0, 1'b1, 32'd1040, 32'h00000000, low, welow);
    chk("b2b read low (one idle between)", 32'(low), 32'd5);
    chk("b2b read data", read_data[1], 32'hDEADBEEF);
    go_idle(1);

    // Reset on the 2nd LO cycle of a write.
    @(negedge clk);
    wr_en[1]      = 1'b1;
    address[1]    = 32'd1048;
    write_data[1] = 32'h11112222;
    @(negedge clk);
    @(negedge clk);
    pre13  = mem1[13];
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    #1;
    chk("abort we_n", {31'd0, sram_we_n[1]}, 32'd1);
    chk("abort oe", {31'd0, sram_dq_oe[1]}, 32'd0);
    chk("abort sram_addr", {14'd0, sram_addr[1]}, 32'd0);
    chk("abort read_data cleared", read_data[1], 32'd0);
    chk("abort hi half untouched", {16'd0, mem1[13]}, {16'd0, pre13});
    wait_done(1, low, welow);
    chk("restart low", 32'(low), 32'd5);
    chk("restart we_n low", 32'(welow), 32'd4);
    go_idle(1);
    @(negedge clk);
    chk("restart mem1[12]", {16'd0, mem1[12]}, 32'h2222);
    chk("restart mem1[13]", {16'd0, mem1[13]}, 32'h1111);
    chk("restart read_data", read_data[1], 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: extra wait cycles per 16-bit SRAM half access (range 0..15).
REQ-002 Parameter ADDR_BASE, default 1024: byte address that maps to SRAM word 0.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  MEM-stage store request; held stable while ready=0.
REQ-006 rd_en  input  1  MEM-stage load request; held stable while ready=0.
REQ-007 address  input  32  byte address from ALU result.
REQ-008 write_data  input  32  store data (Val_Rm).
REQ-009 read_data  output  32  load result; valid in DONE and held afterwards.
REQ-010 ready  output  1  low means pipeline freeze; high means access complete or no access pending.
REQ-011 sram_addr  output  18  SRAM half-word address.
REQ-012 sram_dq_out  output  16  SRAM write data.
REQ-013 sram_dq_in  input  16  SRAM read data.
REQ-014 sram_dq_oe  output  1  drive-enable for the sram_dq_out bus.
REQ-015 sram_we_n  output  1  active-low SRAM write strobe.

Function
REQ-016 FSM states: IDLE, LO, HI, DONE; each of LO and HI lasts exactly WAIT_CYCLES+1 cycles, counted by a 4-bit wait counter.
REQ-017 IDLE with wr_en or rd_en set: next state LO and counter cleared; otherwise stay in IDLE.
REQ-018 LO with counter=WAIT_CYCLES: next state HI and counter cleared; HI with counter=WAIT_CYCLES: next state DONE.
REQ-019 DONE: next state IDLE unconditionally; requests still asserted during DONE are ignored.
REQ-020 ready is combinational.
  - In IDLE: ready = !(wr_en|rd_en).
  - In LO/HI: ready = 0.
  - In DONE: ready = 1.
  - Resulting freeze length: 2*(WAIT_CYCLES+1)+1 cycles.
REQ-021 Word index = (address - ADDR_BASE) >> 2, truncated to 17 bits (mod 2^17 wrap).
  - sram_addr = {index, 0} in LO.
  - sram_addr = {index, 1} in HI.
REQ-022 Write data: sram_dq_out = write_data[15:0] in LO and write_data[31:16] in HI.
REQ-023 If wr_en is set in LO/HI: sram_dq_oe=1 and sram_we_n=0 on every cycle of LO/HI; otherwise sram_dq_oe=0 and sram_we_n=1.
REQ-024 If wr_en and rd_en are both set in IDLE, the access is a write.
  - The access type is latched on leaving IDLE.
  - Input changes during LO/HI do not alter the access type.
REQ-025 On a read, sram_dq_in is captured on the last cycle of LO into read_data[15:0] and on the last cycle of HI into read_data[31:16].
REQ-026 read_data is unchanged by writes and idle cycles.
REQ-027 sram_addr and sram_dq_out are 0 in IDLE and DONE.

Reset
REQ-028 rst has priority over all transitions; in the same edge it forces:
  - state=IDLE, counter=0, read_data=0, latched type=read;
  - sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
REQ-029 rst asserted during LO/HI aborts the access; no write strobe appears in the cycle after the reset edge.
REQ-030 After rst deasserts, a still-asserted request starts a fresh access from IDLE.

Structure
REQ-031 A shared package holds:
  - the FSM state encoding (2 bits);
  - default constants SRAM_WAIT_CYCLES=1, SRAM_ADDR_BASE=1024, SRAM_ADDR_W=18, SRAM_DATA_W=16.
REQ-032 The block is a single module with no sub-modules; it is instantiated in the top level beside the MEM stage.
REQ-033 The top level ORs !ready into the pipeline freeze that holds IF, REG_PIPE_1 through REG_PIPE_4 and the PC.

Verification
REQ-034 WAIT_CYCLES=1; write 0x12345678 at 1024.
  - ready=0 for 5 cycles.
  - SRAM[0]=0x5678 and SRAM[1]=0x1234.
  - sram_we_n is low for exactly 4 cycles.
REQ-035 Read at 1024 after REQ-034: ready=1 on cycle 6 with read_data=0x12345678, and read_data holds that value afterwards.
REQ-036 WAIT_CYCLES=0; write 0xCAFEBABE at 1028: ready low 3 cycles, SRAM[2]=0xBABE, SRAM[3]=0xCAFE.
REQ-037 rd_en=wr_en=1 at 1032 with write_data=0xA5A5: a write is performed, sram_we_n pulses, read_data is unchanged.
REQ-038 Back-to-back write then read at the same address: both complete with one IDLE cycle between DONEs, and the read returns the written value.
REQ-039 rst pulsed on the 2nd LO cycle of a write: next cycle shows IDLE, we_n=1, oe=0 and SRAM[1] untouched; the held request then restarts and completes normally.
